// File: rtl/cpu_trace_pkg.sv
// cpu_trace_pkg: shared ASCII, record-type, FSM-state and record definitions for the trace emitter/checker
package cpu_trace_pkg;
    localparam logic [7:0] CH_CARET = 8'h5e;
    localparam logic [7:0] CH_AT = 8'h40;
    localparam logic [7:0] CH_COLON = 8'h3a;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_STAR = 8'h2a;
    localparam logic [7:0] CH_LT = 8'h3c;
    localparam logic [7:0] CH_EQ = 8'h3d;
    localparam logic [7:0] CH_HASH = 8'h23;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_ZERO = 8'h30;
    localparam logic [7:0] CH_A = 8'h61;
    localparam logic TRACE_GRF = 1'b0;
    localparam logic TRACE_MEM = 1'b1;
    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_CARET = 4'd1;
    localparam logic [3:0] ST_TIME = 4'd2;
    localparam logic [3:0] ST_AT = 4'd3;
    localparam logic [3:0] ST_PC = 4'd4;
    localparam logic [3:0] ST_COLON = 4'd5;
    localparam logic [3:0] ST_SPACE = 4'd6;
    localparam logic [3:0] ST_SIGIL = 4'd7;
    localparam logic [3:0] ST_FIELD = 4'd8;
    localparam logic [3:0] ST_ARROW = 4'd9;
    localparam logic [3:0] ST_DATA = 4'd10;
    localparam logic [3:0] ST_HASH = 4'd11;
    // Decimal fields are stored left-aligned so the index counter reads digits MSB-first.
    typedef struct packed {
        logic typ;
        logic [15:0] tim;
        logic [2:0] td;
        logic [31:0] pc;
        logic [7:0] grf;
        logic [1:0] gd;
        logic [31:0] addr;
        logic [31:0] data;
    } trace_rec_t;
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return n < 4'd10 ? CH_ZERO + 8'(n) : CH_A + 8'(n - 4'd10);
    endfunction
endpackage

// File: rtl/trace_bin2bcd.sv
// trace_bin2bcd: combinational double-dabble, bin (14b binary) -> bcd (4 BCD digits)
module trace_bin2bcd (
    input  logic [13:0] bin,
    output logic [15:0] bcd
);
    logic [29:0] s;
    always_comb begin
        s = {16'b0, bin};
        for (int i = 0; i < 14; i++) begin
            for (int j = 0; j < 4; j++)
                s[14+4*j +: 4] = s[14+4*j +: 4] + (s[14+4*j +: 4] > 4'd4 ? 4'd3 : 4'd0);
            s = s << 1;
        end
        bcd = s[29:14];
    end
endmodule

// File: rtl/cpu_trace_emitter.sv
// cpu_trace_emitter: serializes one write-back record per accepted request into an ASCII trace, one char per clock
// in_valid/in_ready handshake with in_type/in_time/in_pc/in_grf/in_addr/in_data captured at accept;
// char/char_valid/done are registered stream outputs, done marks the closing '#'.
module cpu_trace_emitter
    import cpu_trace_pkg::*;
#(
    parameter logic [7:0] IDLE_CHAR = 8'h00,
    parameter int TIME_MAX = 9999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_type,
    input  logic [15:0] in_time,
    input  logic [31:0] in_pc,
    input  logic [4:0]  in_grf,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_data,
    output logic [7:0]  char,
    output logic        char_valid,
    output logic        done
);
    logic [3:0] state_q, state_d, idx_q, idx_d, lim;
    logic [7:0] char_q, char_d;
    logic char_valid_q, char_valid_d, done_q, done_d;
    trace_rec_t rec_q, rec_d, rec_new;
    logic [15:0] bcd;
    logic [1:0] tens;
    logic [4:0] ones;
    logic acc, multi, advance;
    trace_bin2bcd u_bcd (
        .bin(14'(in_time > 16'(TIME_MAX) ? 16'(TIME_MAX) : in_time)),
        .bcd(bcd)
    );
    assign in_ready = state_q == ST_IDLE || state_q == ST_HASH;
    assign acc = in_valid && in_ready;
    always_comb begin
        tens = in_grf >= 5'd30 ? 2'd3 : in_grf >= 5'd20 ? 2'd2 : in_grf >= 5'd10 ? 2'd1 : 2'd0;
        ones = in_grf - 5'(tens) * 5'd10;
        rec_new.typ = in_type;
        rec_new.td = bcd[15:12] != 0 ? 3'd4 : bcd[11:8] != 0 ? 3'd3 : bcd[7:4] != 0 ? 3'd2 : 3'd1;
        rec_new.tim = bcd << {3'd4 - rec_new.td, 2'b00};
        rec_new.pc = in_pc;
        rec_new.grf = tens != 2'd0 ? {2'b00, tens, ones[3:0]} : {ones[3:0], 4'h0};
        rec_new.gd = tens != 2'd0 ? 2'd2 : 2'd1;
        rec_new.addr = in_addr;
        rec_new.data = in_data;
        rec_d = acc ? rec_new : rec_q;
        multi = state_q == ST_TIME || state_q == ST_PC || state_q == ST_FIELD || state_q == ST_ARROW || state_q == ST_DATA;
        lim = state_q == ST_TIME ? 4'(rec_q.td - 3'd1) :
              state_q == ST_FIELD ? (rec_q.typ ? 4'd7 : 4'(rec_q.gd - 2'd1)) :
              state_q == ST_ARROW ? 4'd3 : 4'd7;
        advance = !multi || idx_q == lim;
        state_d = (state_q == ST_IDLE || state_q == ST_HASH) ? (acc ? ST_CARET : ST_IDLE) :
                  advance ? state_q + 4'd1 : state_q;
        idx_d = (multi && !advance) ? idx_q + 4'd1 : 4'd0;
        // Character is chosen for the state being entered so the output register lines up with it.
        case (state_d)
            ST_CARET: char_d = CH_CARET;
            ST_TIME:  char_d = hex_char(4'(rec_q.tim >> {2'd3 - idx_d[1:0], 2'b00}));
            ST_AT:    char_d = CH_AT;
            ST_PC:    char_d = hex_char(4'(rec_q.pc >> {3'd7 - idx_d[2:0], 2'b00}));
            ST_COLON: char_d = CH_COLON;
            ST_SPACE: char_d = CH_SPACE;
            ST_SIGIL: char_d = rec_q.typ ? CH_STAR : CH_DOLLAR;
            ST_FIELD: char_d = rec_q.typ ? hex_char(4'(rec_q.addr >> {3'd7 - idx_d[2:0], 2'b00})) :
                               hex_char(idx_d[0] ? rec_q.grf[3:0] : rec_q.grf[7:4]);
            ST_ARROW: char_d = idx_d == 4'd1 ? CH_LT : idx_d == 4'd2 ? CH_EQ : CH_SPACE;
            ST_DATA:  char_d = hex_char(4'(rec_q.data >> {3'd7 - idx_d[2:0], 2'b00}));
            ST_HASH:  char_d = CH_HASH;
            default:  char_d = IDLE_CHAR;
        endcase
        char_valid_d = state_d != ST_IDLE;
        done_d = state_d == ST_HASH;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q <= 4'd0;
            char_q <= IDLE_CHAR;
            char_valid_q <= 1'b0;
            done_q <= 1'b0;
            rec_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            char_q <= char_d;
            char_valid_q <= char_valid_d;
            done_q <= done_d;
            rec_q <= rec_d;
        end
    end
    assign char = char_q;
    assign char_valid = char_valid_q;
    assign done = done_q;
endmodule

// File: tb/tb_cpu_trace_emitter.sv
// tb_cpu_trace_emitter: directed record vectors plus reset and back-to-back sequences for cpu_trace_emitter
module tb_cpu_trace_emitter;
    logic clk = 1'b0;
    logic reset, in_valid, in_ready, in_type, char_valid, done;
    logic [15:0] in_time;
    logic [31:0] in_pc, in_addr, in_data;
    logic [4:0] in_grf;
    logic [7:0] char;
    int tests = 0;
    int errors = 0;
    always #5 clk = ~clk;
    cpu_trace_emitter dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_type(in_type), .in_time(in_time), .in_pc(in_pc), .in_grf(in_grf),
        .in_addr(in_addr), .in_data(in_data), .char(char), .char_valid(char_valid), .done(done)
    );
    typedef struct packed {
        logic typ;
        logic [15:0] tim;
        logic [31:0] pc;
        logic [4:0] grf;
        logic [31:0] addr;
        logic [31:0] data;
        logic [7:0] len;
        logic [319:0] exp;
    } vec_t;
    vec_t vecs[8];
    function automatic vec_t mk(input logic typ, input logic [15:0] tim, input logic [31:0] pc,
                                input logic [4:0] grf, input logic [31:0] addr, input logic [31:0] data,
                                input logic [7:0] len, input string s);
        vec_t v;
        v.typ = typ; v.tim = tim; v.pc = pc; v.grf = grf; v.addr = addr; v.data = data; v.len = len;
        v.exp = '0;
        for (int i = 0; i < s.len(); i++) v.exp = (v.exp << 8) | 320'(s[i]);
        return v;
    endfunction
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask
    task automatic drive(input vec_t v);
        in_valid = 1'b1; in_type = v.typ; in_time = v.tim; in_pc = v.pc;
        in_grf = v.grf; in_addr = v.addr; in_data = v.data;
    endtask
    task automatic scramble();
        in_type = ~in_type; in_time = 16'($urandom); in_pc = $urandom;
        in_grf = 5'($urandom); in_addr = $urandom; in_data = $urandom;
    endtask
    // Gathers characters until '#' (done), an idle cycle, or a 60-cycle bound.
    task automatic collect(output logic [319:0] got, output int n, output int done_at, output int done_cnt);
        got = '0; n = 0; done_at = -1; done_cnt = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (!char_valid) break;
            got = (got << 8) | 320'(char);
            if (done) begin
                done_cnt++;
                done_at = n;
            end
            n++;
            if (done) break;
        end
    endtask
    task automatic check_rec(input string name, input vec_t v, input logic [319:0] got,
                             input int n, input int done_at, input int done_cnt);
        tests++;
        if (got !== v.exp) begin
            errors++;
            $display("FAIL %s stream: got \"%s\" expected \"%s\"", name, got, v.exp);
        end
        check({name, " length"}, 64'(n), 64'(v.len));
        check({name, " done count"}, 64'(done_cnt), 64'd1);
        check({name, " done position"}, 64'(done_at), 64'(v.len) - 64'd1);
    endtask
    task automatic run_rec(input string name, input vec_t v);
        logic [319:0] got;
        int n, da, dc;
        check({name, " ready before"}, 64'(in_ready), 64'd1);
        drive(v);
        @(posedge clk);
        #1;
        scramble();
        in_valid = 1'b0;
        collect(got, n, da, dc);
        check_rec(name, v, got, n, da, dc);
        @(negedge clk);
        check({name, " idle after"}, {55'd0, char_valid, char}, 64'd0);
    endtask
    initial begin
        logic [319:0] got_a, got_b;
        int na, daa, dca, nb, dab, dcb, stray;
        vecs[0] = mk(1'b0, 16'd10, 32'h3000, 5'd1, 32'h0, 32'h1, 8'd29, "^10@00003000: $1 <= 00000001#");
        vecs[1] = mk(1'b1, 16'd0, 32'h3004, 5'd0, 32'h1ffc, 32'hdeadbeef, 8'd35, "^0@00003004: *00001ffc <= deadbeef#");
        vecs[2] = mk(1'b0, 16'd12345, 32'h00400000, 5'd31, 32'h0, 32'h12345678, 8'd32, "^9999@00400000: $31 <= 12345678#");
        vecs[3] = mk(1'b0, 16'd9999, 32'hffffffff, 5'd10, 32'h0, 32'h0, 8'd32, "^9999@ffffffff: $10 <= 00000000#");
        vecs[4] = mk(1'b1, 16'd123, 32'habcdef01, 5'd0, 32'h10, 32'ha5a5, 8'd37, "^123@abcdef01: *00000010 <= 0000a5a5#");
        vecs[5] = mk(1'b0, 16'd5, 32'h3008, 5'd0, 32'h0, 32'hcafef00d, 8'd28, "^5@00003008: $0 <= cafef00d#");
        vecs[6] = mk(1'b0, 16'd10000, 32'h3010, 5'd9, 32'h0, 32'h7, 8'd31, "^9999@00003010: $9 <= 00000007#");
        vecs[7] = mk(1'b0, 16'd1, 32'h3002, 5'd2, 32'h0, 32'h10, 8'd28, "^1@00003002: $2 <= 00000010#");
        reset = 1'b1; in_valid = 1'b0; in_type = 1'b0; in_time = '0; in_pc = '0;
        in_grf = '0; in_addr = '0; in_data = '0;
        repeat (3) @(negedge clk);
        check("reset char", 64'(char), 64'h00);
        check("reset char_valid", 64'(char_valid), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd1);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) run_rec($sformatf("vec%0d", i), vecs[i]);
        // Reset and request on the same edge: reset wins.
        reset = 1'b1;
        drive(vecs[0]);
        @(posedge clk);
        #1;
        reset = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("reset+valid not accepted", {55'd0, char_valid, char}, 64'd0);
        @(negedge clk);
        check("reset+valid still idle", 64'(char_valid), 64'd0);
        // Reset on the 10th character abandons the record.
        drive(vecs[0]);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("char 10 before reset", 64'(char), 64'h30);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("mid reset output", {54'd0, done, char_valid, char}, 64'd0);
        stray = 0;
        repeat (40) begin
            @(negedge clk);
            if (char_valid || done) stray++;
        end
        check("abandoned record stays idle", 64'(stray), 64'd0);
        run_rec("after reset", vecs[5]);
        // Back-to-back: record 2 held on the inputs while record 1 streams.
        drive(vecs[1]);
        @(posedge clk);
        #1;
        drive(vecs[2]);
        collect(got_a, na, daa, dca);
        check("b2b ready during hash", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        scramble();
        in_valid = 1'b0;
        collect(got_b, nb, dab, dcb);
        check_rec("b2b first", vecs[1], got_a, na, daa, dca);
        check_rec("b2b second", vecs[2], got_b, nb, dab, dcb);
        @(negedge clk);
        check("b2b idle after", {55'd0, char_valid, char}, 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule

// File: doc/cpu_trace_emitter.md
# cpu_trace_emitter

Serializes one CPU write-back record per request into the ASCII trace stream consumed by `cpu_checker`, one character per clock. Formats:
- register write: `^<time>@<pc>: $<grf> <= <data>#`
- memory write: `^<time>@<pc>: *<addr> <= <data>#`

It is the producer end of that character protocol: it drives checker benches and CPU trace ports.

## Interface
- `IDLE_CHAR`, 8'h00: value of `char` whenever `char_valid` = 0.
- `TIME_MAX`, 9999: saturation limit for `in_time`; must be at most 9999 so the field stays within 4 digits.
- `clk` in 1: single clock, all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: request holds a record.
- `in_ready` out 1: block accepts a record this cycle.
- `in_type` in 1: 0 = register record (`$`), 1 = memory record (`*`).
- `in_time` in 16: cycle time, unsigned decimal.
- `in_pc` in 32: PC, emitted verbatim.
- `in_grf` in 5: register number.
- `in_addr` in 32: memory address, emitted verbatim.
- `in_data` in 32: written data.
- `char` out 8: current ASCII character.
- `char_valid` out 1: `char` is part of a record.
- `done` out 1: one-cycle pulse coincident with `#`.

## Operation
- **Accept:** a record is accepted when `in_valid && in_ready`. All fields are captured into registers at that edge, so inputs may change afterwards.
- **Time field:**
  - `in_time` is clamped to `TIME_MAX`.
  - The clamped value is converted to 4 BCD digits at capture.
  - Leading zeros are suppressed; time 0 emits the single digit `0`.
  - Digit count `td` is 1–4.
- **PC, addr, data fields:** exactly 8 lowercase hex digits each, most significant first, zero-padded.
- **GRF field:** decimal, no leading zeros, `gd` = 1 or 2 digits (e.g. 0 → `0`, 31 → `31`).
- **Separator sequence:** `:` is followed by exactly one space, then the sigil. `<=` is preceded and followed by exactly one space.
- **FSM states:** IDLE → CARET → TIME → AT → PC → COLON → SPACE → SIGIL → FIELD → ARROW → DATA → HASH.
  - A 4-bit index counter steps through the multi-character states TIME, PC, FIELD, ARROW and DATA.
  - FIELD emits grf digits when `in_type` = 0 and 8 addr hex digits when `in_type` = 1.
  - ARROW emits the 4 characters space, `<`, `=`, space.
- **Record length:**
  - register record: 26 + `td` + `gd` characters.
  - memory record: 34 + `td` characters.
- **`in_ready`:** high in IDLE and in HASH. A record accepted during HASH starts with `^` on the very next cycle, so back-to-back records have no gap.
- **Leaving HASH:** from HASH the FSM goes to CARET if a record was accepted, otherwise to IDLE.
- **Input-range checks:** none. Out-of-range pc/addr values are emitted as given, so the bench can provoke checker error codes.

## Timing
- **Reset values:** `char` = `IDLE_CHAR`, `char_valid` = 0, `done` = 0, state IDLE, `in_ready` = 1.
- **Output timing:**
  - `char`, `char_valid` and `done` are registered.
  - `in_ready` is combinational from state only, with no path from `in_valid`.
- **Latency:** accept at edge N puts `^` on `char` in cycle N+1. Each subsequent character follows at 1 per cycle with no stalls or backpressure.
- **`done`:** high only in the `#` cycle.
- **Reset mid-record:** the record is abandoned at once. The next cycle shows `IDLE_CHAR` with `char_valid` = 0 and no `done`, and the partial record is never completed.
- **Reset together with a request:** if reset and `in_valid` are both high at an edge, reset wins and the request is not accepted.

## Structure
- **Shared package `cpu_trace_pkg`:**
  - ASCII constants: `^ @ : $ * < = #`, space, `0`, `a`.
  - Record-type constants: `TRACE_GRF` = 0, `TRACE_MEM` = 1.
  - FSM state encoding.
  - Helper function mapping a 4-bit nibble to a lowercase hex ASCII character.

  The checker reuses the ASCII constants and record-type constants.
- **Sub-module `trace_bin2bcd`:** combinational double-dabble, 14-bit binary to 4 BCD digits. It is used once for time; grf decimal uses a simple ≥10 compare/subtract in the top module.

## Test plan
- Register record, time 10, pc 0x3000, grf 1, data 1 → stream `^10@00003000: $1 <= 00000001#`, 29 characters, `done` in character 29, checker `format_type` = 01, `error_code` = 0.
- Memory record, time 0, pc 0x3004, addr 0x1ffc, data 0xdeadbeef → `^0@00003004: *00001ffc <= deadbeef#`, 35 characters, checker `format_type` = 10.
- Time 12345 and grf 31 → time field `9999`, grf field `31`, record length 32.
- Two records with `in_valid` held high → `^` of record 2 appears in the cycle directly after `#` of record 1; `in_ready` is high during `#`.
- Reset asserted on the 10th character → the next cycle has `char_valid` = 0, `char` = 8'h00 and no `done`. A new request then produces a complete record.
- Pc 0x3002 with pc field changed after the accept → the stream shows `00003002`, and the checker raises `error_code` bit 1.
